triangle_assembler: RTL and testbench

- Sits directly downstream of the vertex projector.
- Consumes the stream of projected vertex_t (screen-space x/y in q16_16, z preserved), groups vertices into triangles of three, rejects triangles that violate the near plane, optionally culls back-facing ones, and presents surviving triangles to the rasterizer setup stage.
- Valid/ready on both sides.
- Keeps status counters for debug readback.

---
 rtl/triangle_assembler_if.sv | 27 ++
 rtl/triangle_assembler.sv | 154 +++++++++++++++
 tb/tb_triangle_assembler.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/triangle_assembler_if.sv
// Vertex-in / triangle-out stream bundle for triangle_assembler.
// Vertex layout (96 bits): x = [95:64], y = [63:32], z = [31:0], each signed q16_16.
interface triangle_assembler_if #(
  parameter int VW = 96
);
  logic [VW-1:0] in_vertex;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [VW-1:0] out_v0;
  logic [VW-1:0] out_v1;
  logic [VW-1:0] out_v2;
  logic          out_valid;
  logic          out_ready;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valid and its payload hold until that edge, ready may toggle freely.
  modport master (
    output in_vertex, in_valid, flush, out_ready,
    input  in_ready, out_v0, out_v1, out_v2, out_valid
  );

  modport slave (
    input  in_vertex, in_valid, flush, out_ready,
    output in_ready, out_v0, out_v1, out_v2, out_valid
  );
endinterface

// File: rtl/triangle_assembler.sv
// Groups projected vertices into triangles, rejects near-plane violators and
// presents survivors downstream. Optional back-face culling: TRI_BACKFACE_CULL_EN.
module triangle_assembler #(
  parameter logic signed [31:0] NEAR_Z    = 32'sh0000_1000,
  parameter bit                 CCW_FRONT = 1'b1,
  parameter int                 CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  triangle_assembler_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] tri_out_count,
  output logic [CNT_W-1:0] tri_drop_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [95:0]      r_slot [3];
  logic [95:0]      r_out_v0, r_out_v1, r_out_v2;
  logic             r_out_valid, w_out_valid_nxt;
  logic [CNT_W-1:0] r_out_cnt, r_drop_cnt;

  logic w_slot_we;
  logic w_out_load;
  logic w_out_inc;
  logic w_drop_inc;
  logic w_near_fail;
  logic w_cull;

  assign w_near_fail = ($signed(r_slot[0][31:0]) < NEAR_Z) ||
                       ($signed(r_slot[1][31:0]) < NEAR_Z) ||
                       ($signed(r_slot[2][31:0]) < NEAR_Z);

`ifdef TRI_BACKFACE_CULL_EN
  logic signed [31:0] w_x0, w_y0, w_x1, w_y1, w_x2, w_y2;
  logic signed [32:0] w_ex1, w_ey1, w_ex2, w_ey2;
  logic signed [66:0] w_p1, w_p2, w_area;

  assign w_x0 = r_slot[0][95:64];
  assign w_y0 = r_slot[0][63:32];
  assign w_x1 = r_slot[1][95:64];
  assign w_y1 = r_slot[1][63:32];
  assign w_x2 = r_slot[2][95:64];
  assign w_y2 = r_slot[2][63:32];

  // Edge deltas widened to 33 bits so extreme coordinates never wrap.
  assign w_ex1 = 33'(w_x1) - 33'(w_x0);
  assign w_ey1 = 33'(w_y1) - 33'(w_y0);
  assign w_ex2 = 33'(w_x2) - 33'(w_x0);
  assign w_ey2 = 33'(w_y2) - 33'(w_y0);

  assign w_p1   = 67'(w_ex1) * 67'(w_ey2);
  assign w_p2   = 67'(w_ey1) * 67'(w_ex2);
  assign w_area = w_p1 - w_p2;

  assign w_cull = (w_area == 67'sd0) ||
                  (CCW_FRONT ? (w_area < 67'sd0) : (w_area > 67'sd0));
`else
  assign w_cull = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_slot_we       = 1'b0;
    w_out_load      = 1'b0;
    w_out_valid_nxt = r_out_valid;
    w_out_inc       = 1'b0;
    w_drop_inc      = 1'b0;
    unique case (r_state)
      COLLECT: begin
        if (bus.flush) begin
          w_idx_nxt = 2'd0;
        end else if (bus.in_valid) begin
          w_slot_we = 1'b1;
          if (r_idx == 2'd2) begin
            w_idx_nxt   = 2'd0;
            w_state_nxt = EVAL;
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end
      end
      EVAL: begin
        if (w_near_fail || w_cull) begin
          w_drop_inc  = 1'b1;
          w_state_nxt = COLLECT;
        end else begin
          w_out_load      = 1'b1;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = OUTPUT;
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_out_inc       = 1'b1;
          w_state_nxt     = COLLECT;
        end
      end
      default: begin
        w_state_nxt     = COLLECT;
        w_idx_nxt       = 2'd0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_idx       <= 2'd0;
      for (int i = 0; i < 3; i++) r_slot[i] <= '0;
      r_out_v0    <= '0;
      r_out_v1    <= '0;
      r_out_v2    <= '0;
      r_out_valid <= 1'b0;
      r_out_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_slot_we) r_slot[r_idx] <= bus.in_vertex;
      if (w_out_load) begin
        r_out_v0 <= r_slot[0];
        r_out_v1 <= r_slot[1];
        r_out_v2 <= r_slot[2];
      end
      if (w_out_inc)  r_out_cnt  <= r_out_cnt + 1'b1;
      if (w_drop_inc) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // in_ready depends only on registered state, never on out_ready.
  assign bus.in_ready  = (r_state == COLLECT);
  assign bus.out_v0    = r_out_v0;
  assign bus.out_v1    = r_out_v1;
  assign bus.out_v2    = r_out_v2;
  assign bus.out_valid = r_out_valid;

  assign busy           = (r_idx != 2'd0) || (r_state != COLLECT);
  assign tri_out_count  = r_out_cnt;
  assign tri_drop_count = r_drop_cnt;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench for triangle_assembler: vector table plus reset, backpressure
// and flush sequences. Expectations follow TRI_BACKFACE_CULL_EN when defined.
module tb_triangle_assembler;

`ifdef TRI_BACKFACE_CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif
  localparam int CNT_W = 16;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] SMAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic             clk;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] tri_out_count;
  logic [CNT_W-1:0] tri_drop_count;
  logic [1:0]       dbg_state;

  triangle_assembler_if bus ();

  triangle_assembler #(
    .NEAR_Z    (32'sh0000_1000),
    .CCW_FRONT (1'b1),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .busy           (busy),
    .tri_out_count  (tri_out_count),
    .tri_drop_count (tri_drop_count),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int              n_checks = 0;
  int              n_pass   = 0;
  int              exp_out  = 0;
  int              exp_drop = 0;
  logic [287:0]    exp_q[$];

  typedef struct {
    logic [95:0] v0;
    logic [95:0] v1;
    logic [95:0] v2;
    logic        emit;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [95:0] mk(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return {x, y, z};
  endfunction

  task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_out_cnt"},  288'(tri_out_count),  288'(exp_out[CNT_W-1:0]));
    chk({nm, "_drop_cnt"}, 288'(tri_drop_count), 288'(exp_drop[CNT_W-1:0]));
  endtask

  task automatic sb_compare(input string nm);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got triangle %0h expected none", nm,
               {bus.out_v0, bus.out_v1, bus.out_v2});
    end else begin
      chk(nm, {bus.out_v0, bus.out_v1, bus.out_v2}, exp_q.pop_front());
    end
  endtask

  // driver: call at a negedge; returns at the negedge after the accept edge
  task automatic push(input logic [95:0] v);
    int n;
    n = 0;
    bus.in_vertex = v;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      n_checks++;
      $display("FAIL push_timeout: got in_ready 0 expected 1");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_tri(input string nm, input logic [95:0] v0, input logic [95:0] v1,
                         input logic [95:0] v2, input logic emit);
    push(v0);
    push(v1);
    push(v2);
    chk({nm, "_eval_state"}, 288'(dbg_state), 288'(2'd1));
    chk({nm, "_eval_rdy"},   288'({bus.in_ready, bus.out_valid, busy}), 288'(3'b001));
    @(negedge clk);
    if (emit) begin
      exp_q.push_back({v0, v1, v2});
      chk({nm, "_out_valid"}, 288'(bus.out_valid), 288'(1'b1));
      if (bus.out_valid) sb_compare({nm, "_tri"});
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      exp_out++;
      chk({nm, "_after_acc"}, 288'({bus.out_valid, bus.in_ready}), 288'(2'b01));
    end else begin
      exp_drop++;
      chk({nm, "_dropped"}, 288'({bus.out_valid, bus.in_ready, busy}), 288'(3'b010));
    end
    chk_counts(nm);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_vertex = '0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    tbl[0]  = '{mk(0, 0, ONE), mk(ONE, 0, ONE), mk(0, ONE, ONE), 1'b1};
    tbl[1]  = '{mk(0, 0, ONE), mk(ONE, 0, 32'h0000_0800), mk(0, ONE, ONE), 1'b0};
    tbl[2]  = '{mk(0, 0, ONE), mk(0, ONE, ONE), mk(ONE, 0, ONE), !CULL};
    tbl[3]  = '{mk(0, 0, ONE), mk(1, 1, ONE), mk(2, 2, ONE), !CULL};
    tbl[4]  = '{mk(0, 0, ONE), mk(ONE, 0, ONE), mk(0, ONE, 32'hFFFF_0000), 1'b0};
    tbl[5]  = '{mk(0, 0, 32'h1000), mk(ONE, 0, 32'h1000), mk(0, ONE, 32'h1000), 1'b1};
    tbl[6]  = '{mk(0, 0, 32'h0FFF), mk(ONE, 0, ONE), mk(0, ONE, ONE), 1'b0};
    tbl[7]  = '{mk(SMIN, SMIN, ONE), mk(SMAX, SMIN, ONE), mk(SMIN, SMAX, ONE), 1'b1};
    tbl[8]  = '{mk(SMIN, SMIN, ONE), mk(SMIN, SMAX, ONE), mk(SMAX, SMIN, ONE), !CULL};
    tbl[9]  = '{mk(SMIN, 0, ONE), mk(SMAX, 0, ONE), mk(SMIN, ONE, ONE), 1'b1};
    tbl[10] = '{mk(0, 0, ONE), mk(0, ONE, 32'h0000_0001), mk(ONE, 0, ONE), 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_flags", 288'({bus.out_valid, bus.in_ready, busy}), 288'(3'b010));
    chk("reset_state", 288'(dbg_state), 288'(2'd0));
    chk("reset_outs",  {bus.out_v0, bus.out_v1, bus.out_v2}, 288'(0));
    chk_counts("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      run_tri($sformatf("vec%0d", i), tbl[i].v0, tbl[i].v1, tbl[i].v2, tbl[i].emit);

    // backpressure: held triangle stays put, flush and in_valid ignored
    push(tbl[0].v0);
    push(tbl[0].v1);
    push(tbl[0].v2);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_vertex = mk(32'h1234_5678, 0, ONE);
    for (int i = 0; i < 10; i++) begin
      bus.flush = (i == 3);
      chk($sformatf("bp_hold%0d", i),
          {bus.out_valid, bus.in_ready, busy, bus.out_v0, bus.out_v1, bus.out_v2},
          {1'b1, 1'b0, 1'b1, tbl[0].v0, tbl[0].v1, tbl[0].v2});
      @(negedge clk);
    end
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b0;
    exp_out++;
    chk("bp_single_acc", 288'({bus.out_valid, busy}), 288'(2'b00));
    chk_counts("bp");

    // flush after two vertices, with a same-cycle vertex that must be dropped
    push(tbl[7].v0);
    push(tbl[7].v1);
    chk("pre_flush_busy", 288'(busy), 288'(1'b1));
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_vertex = mk(32'hDEAD_0000, 32'hBEEF_0000, ONE);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_busy", 288'({busy, dbg_state}), 288'(3'b000));
    run_tri("post_flush", tbl[5].v0, tbl[5].v1, tbl[5].v2, 1'b1);

    // asynchronous reset while a triangle is presented
    push(tbl[0].v0);
    push(tbl[0].v1);
    push(tbl[0].v2);
    @(negedge clk);
    chk("pre_rst_valid", 288'(bus.out_valid), 288'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    exp_out  = 0;
    exp_drop = 0;
    exp_q.delete();
    chk("rst_async", 288'({bus.out_valid, bus.in_ready, busy}), 288'(3'b010));
    chk_counts("rst_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_tri("after_rst", tbl[9].v0, tbl[9].v1, tbl[9].v2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
